// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: R0..R15, HI/LO, PC, IR, MAR, MDR, Y, 64-bit Z and a
// combinational ALU, all sharing one 32-bit bus driven by one-hot source selects.
module cpu_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        HIout, LOout, Zhighout, Zlowout, PCout, IRout, MDRout, INout,
  input  logic        Cout, Yout, MARout,
  input  logic        Read,
  input  logic        IncPC,
  input  logic        AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
  input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        HIin, LOin, PCin, IRin, Zin, Yin, MARin, MDRin,
  input  logic [31:0] IN,
  output logic [31:0] BusMuxOut,
  output logic [31:0] PC
);

  logic [31:0] r_q [16];
  logic [31:0] hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, y_q;
  logic [63:0] z_q;

  logic [15:0] r_out, r_in;
  logic [31:0] bus;
  logic [31:0] c_ext;
  logic [63:0] alu_res;

  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  assign c_ext     = {{13{ir_q[18]}}, ir_q[18:0]};
  assign BusMuxOut = bus;
  assign PC        = pc_q;

  // Bus mux: lowest-priority source assigned first so higher-priority sources override.
  always_comb begin
    bus = '0;
    if (MARout)   bus = mar_q;
    if (Yout)     bus = y_q;
    if (Cout)     bus = c_ext;
    if (INout)    bus = IN;
    if (MDRout)   bus = mdr_q;
    if (IRout)    bus = ir_q;
    if (PCout)    bus = pc_q;
    if (Zlowout)  bus = z_q[31:0];
    if (Zhighout) bus = z_q[63:32];
    if (LOout)    bus = lo_q;
    if (HIout)    bus = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (r_out[i]) bus = r_q[i];
    end
  end

  logic [31:0] op_a, op_b;
  logic [4:0]  sh;
  logic [31:0] sra_v;
  logic [63:0] prod;

  assign op_a  = y_q;
  assign op_b  = bus;
  assign sh    = op_b[4:0];
  assign sra_v = $signed(op_a) >>> sh;
  // Low 64 bits of the product of sign-extended operands equal the signed 32x32 product.
  assign prod  = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};

  // ALU: strobe priority follows port order; no strobe yields zero.
  always_comb begin
    logic [31:0] quo, rem;
    quo     = '0;
    rem     = '0;
    alu_res = '0;
    if (AND)       alu_res = {32'h0, op_a & op_b};
    else if (OR)   alu_res = {32'h0, op_a | op_b};
    else if (ADD)  alu_res = {32'h0, op_a + op_b};
    else if (SUB)  alu_res = {32'h0, op_a - op_b};
    else if (MUL)  alu_res = prod;
    else if (DIV) begin
      if (op_b == 32'h0) begin
        alu_res = {op_a, 32'hFFFF_FFFF};
      end else if (op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF) begin
        // Overflowing quotient wraps; avoids the undefined signed-division corner.
        alu_res = {32'h0, 32'h8000_0000};
      end else begin
        quo     = $signed(op_a) / $signed(op_b);
        rem     = $signed(op_a) % $signed(op_b);
        alu_res = {rem, quo};
      end
    end
    else if (SHR)  alu_res = {32'h0, op_a >> sh};
    else if (SHRA) alu_res = {32'h0, sra_v};
    else if (SHL)  alu_res = {32'h0, op_a << sh};
    else if (ROR)  alu_res = {32'h0, (op_a >> sh) | (op_a << (6'd32 - {1'b0, sh}))};
    else if (ROL)  alu_res = {32'h0, (op_a << sh) | (op_a >> (6'd32 - {1'b0, sh}))};
    else if (NEG)  alu_res = {32'h0, 32'h0 - op_b};
    else if (NOT)  alu_res = {32'h0, ~op_b};
  end

  // Register file and special registers: synchronous reset, then per-register load enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (r_in[i]) r_q[i] <= bus;
      end
      if (HIin)  hi_q  <= bus;
      if (LOin)  lo_q  <= bus;
      if (IRin)  ir_q  <= bus;
      if (MARin) mar_q <= bus;
      if (Yin)   y_q   <= bus;
      if (Zin)   z_q   <= alu_res;
      if (MDRin) mdr_q <= Read ? IN : bus;
      if (PCin)  pc_q  <= IncPC ? pc_q + 32'd1 : bus;
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: directed scenarios plus random register-transfer / ALU traffic,
// checked against an architectural model of the register state.
module tb_cpu_datapath;

  // Source codes (index into sel)
  localparam int S_HI = 16, S_LO = 17, S_ZH = 18, S_ZL = 19, S_PC = 20, S_IR = 21;
  localparam int S_MDR = 22, S_IN = 23, S_C = 24, S_Y = 25, S_MAR = 26;
  // Destination codes (index into en)
  localparam int D_HI = 16, D_LO = 17, D_PC = 18, D_IR = 19, D_Y = 20, D_MAR = 21, D_MDR = 22;
  // Op codes (index into ops, port order); 13 = no strobe
  localparam int OP_AND = 0, OP_OR = 1, OP_ADD = 2, OP_SUB = 3, OP_MUL = 4, OP_DIV = 5;
  localparam int OP_SHR = 6, OP_SHRA = 7, OP_SHL = 8, OP_ROR = 9, OP_ROL = 10;
  localparam int OP_NEG = 11, OP_NOT = 12, OP_NONE = 13;

  logic        clk = 1'b0;
  logic        reset;
  logic [26:0] sel;
  logic [22:0] en;
  logic [12:0] ops;
  logic        read, inc_pc, z_in;
  logic [31:0] in_data;
  logic [31:0] bus, pc;

  int checks = 0;
  int errors = 0;

  // Architectural model
  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y;
  logic [63:0] m_z;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .clk(clk), .reset(reset),
    .R0out(sel[0]), .R1out(sel[1]), .R2out(sel[2]), .R3out(sel[3]),
    .R4out(sel[4]), .R5out(sel[5]), .R6out(sel[6]), .R7out(sel[7]),
    .R8out(sel[8]), .R9out(sel[9]), .R10out(sel[10]), .R11out(sel[11]),
    .R12out(sel[12]), .R13out(sel[13]), .R14out(sel[14]), .R15out(sel[15]),
    .HIout(sel[16]), .LOout(sel[17]), .Zhighout(sel[18]), .Zlowout(sel[19]),
    .PCout(sel[20]), .IRout(sel[21]), .MDRout(sel[22]), .INout(sel[23]),
    .Cout(sel[24]), .Yout(sel[25]), .MARout(sel[26]),
    .Read(read), .IncPC(inc_pc),
    .AND(ops[0]), .OR(ops[1]), .ADD(ops[2]), .SUB(ops[3]), .MUL(ops[4]), .DIV(ops[5]),
    .SHR(ops[6]), .SHRA(ops[7]), .SHL(ops[8]), .ROR(ops[9]), .ROL(ops[10]),
    .NEG(ops[11]), .NOT(ops[12]),
    .R0in(en[0]), .R1in(en[1]), .R2in(en[2]), .R3in(en[3]),
    .R4in(en[4]), .R5in(en[5]), .R6in(en[6]), .R7in(en[7]),
    .R8in(en[8]), .R9in(en[9]), .R10in(en[10]), .R11in(en[11]),
    .R12in(en[12]), .R13in(en[13]), .R14in(en[14]), .R15in(en[15]),
    .HIin(en[16]), .LOin(en[17]), .PCin(en[18]), .IRin(en[19]), .Zin(z_in),
    .Yin(en[20]), .MARin(en[21]), .MDRin(en[22]),
    .IN(in_data), .BusMuxOut(bus), .PC(pc)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_ctl();
    sel = '0; en = '0; ops = '0; read = 1'b0; inc_pc = 1'b0; z_in = 1'b0;
  endtask

  function automatic logic [31:0] bus_ref(int src);
    case (src)
      S_HI:    return m_hi;
      S_LO:    return m_lo;
      S_ZH:    return m_z[63:32];
      S_ZL:    return m_z[31:0];
      S_PC:    return m_pc;
      S_IR:    return m_ir;
      S_MDR:   return m_mdr;
      S_IN:    return in_data;
      S_C:     return 32'($signed(m_ir[18:0]));
      S_Y:     return m_y;
      S_MAR:   return m_mar;
      default: return (src >= 0 && src < 16) ? m_r[src] : 32'h0;
    endcase
  endfunction

  task automatic model_write(int dst, logic [31:0] v);
    case (dst)
      D_HI:  m_hi  = v;
      D_LO:  m_lo  = v;
      D_PC:  m_pc  = v;
      D_IR:  m_ir  = v;
      D_Y:   m_y   = v;
      D_MAR: m_mar = v;
      D_MDR: m_mdr = v;
      default: if (dst >= 0 && dst < 16) m_r[dst] = v;
    endcase
  endtask

  // Arithmetic definition of each operation, independent of any hardware structure.
  function automatic logic [63:0] alu_ref(int op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    int s;
    logic [31:0] v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = int'(b[4:0]);
    v  = '0;
    case (op)
      OP_AND:  v = a & b;
      OP_OR:   v = a | b;
      OP_ADD:  v = a + b;
      OP_SUB:  v = a - b;
      OP_MUL:  return 64'(sa * sb);
      OP_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_SHR:  for (int i = 0; i < 32; i++) v[i] = (i + s < 32) ? a[i + s] : 1'b0;
      OP_SHRA: for (int i = 0; i < 32; i++) v[i] = (i + s < 32) ? a[i + s] : a[31];
      OP_SHL:  for (int i = 0; i < 32; i++) v[i] = (i >= s) ? a[i - s] : 1'b0;
      OP_ROR:  for (int i = 0; i < 32; i++) v[i] = a[(i + s) % 32];
      OP_ROL:  for (int i = 0; i < 32; i++) v[i] = a[(i - s + 32) % 32];
      OP_NEG:  v = 32'h0 - b;
      OP_NOT:  v = ~b;
      default: v = '0;
    endcase
    return {32'h0, v};
  endfunction

  // One register-transfer cycle: src onto bus, dst loads it.
  task automatic xfer(int src, int dst, string tag);
    logic [31:0] b;
    clear_ctl();
    if (src >= 0) sel[src] = 1'b1;
    if (dst >= 0) en[dst] = 1'b1;
    #1;
    b = bus_ref(src);
    chk(tag, bus, b);
    @(posedge clk);
    if (dst >= 0) model_write(dst, b);
    #1;
    clear_ctl();
    chk("pc", pc, m_pc);
  endtask

  // Drive a source, compare the bus with an explicit value, then idle one cycle.
  task automatic peek(int src, string tag, logic [31:0] exp);
    clear_ctl();
    sel[src] = 1'b1;
    #1;
    chk(tag, bus, exp);
    clear_ctl();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_read(logic [31:0] v, bit fetch);
    clear_ctl();
    in_data = v;
    read = 1'b1;
    en[D_MDR] = 1'b1;
    if (fetch) begin
      en[D_PC] = 1'b1;
      inc_pc = 1'b1;
    end
    @(posedge clk);
    m_mdr = v;
    if (fetch) m_pc = m_pc + 32'd1;
    #1;
    clear_ctl();
    chk("pc_mem", pc, m_pc);
  endtask

  task automatic load_reg(int dst, logic [31:0] v);
    mem_read(v, 1'b0);
    xfer(S_MDR, dst, "load");
  endtask

  task automatic alu(int a_src, int b_src, int op);
    logic [31:0] b;
    xfer(a_src, D_Y, "opA");
    clear_ctl();
    sel[b_src] = 1'b1;
    if (op < OP_NONE) ops[op] = 1'b1;
    z_in = 1'b1;
    #1;
    b = bus_ref(b_src);
    chk("opB", bus, b);
    @(posedge clk);
    m_z = alu_ref(op, m_y, b);
    #1;
    clear_ctl();
  endtask

  initial begin
    int op, s, d;
    clear_ctl();
    in_data = 32'hDEAD_BEEF;

    // Reset overrides every load enable, including PCin+IncPC.
    reset = 1'b1;
    en = '1;
    z_in = 1'b1;
    inc_pc = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_ctl();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    {m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y} = '0;
    m_z = '0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_bus_idle", bus, 32'h0);
    for (int i = 0; i <= S_MAR; i++) begin
      if (i != S_IN) peek(i, "rst_reg", 32'h0);
    end

    // Load and NEG
    mem_read(32'h22, 1'b0);
    xfer(S_MDR, 0, "mdr_to_r0");
    peek(0, "r0_load", 32'h22);
    alu(3, 0, OP_NEG);
    xfer(S_ZL, 5, "zl_to_r5");
    peek(5, "neg", 32'hFFFF_FFDE);

    // Instruction fetch with PC increment
    mem_read(32'h8A80_0000, 1'b1);
    chk("fetch_pc", pc, 32'h1);
    xfer(S_MDR, D_IR, "mdr_to_ir");
    peek(S_IR, "ir", 32'h8A80_0000);
    peek(S_C, "c_ext", 32'h0);

    // ADD / SUB
    load_reg(7, 32'h24);
    load_reg(4, 32'h28);
    alu(7, 4, OP_ADD);
    peek(S_ZL, "add", 32'h4C);
    alu(7, 4, OP_SUB);
    peek(S_ZL, "sub_lo", 32'hFFFF_FFFC);
    peek(S_ZH, "sub_hi", 32'h0);

    // Bus priority: R4 beats R7 and MAR
    clear_ctl();
    sel[7] = 1'b1; sel[4] = 1'b1; sel[S_MAR] = 1'b1;
    #1;
    chk("bus_prio", bus, 32'h28);
    // Strobe priority: AND beats ADD (Y = 0x24 still)
    sel = '0; sel[4] = 1'b1;
    ops[OP_AND] = 1'b1; ops[OP_ADD] = 1'b1; z_in = 1'b1;
    @(posedge clk);
    #1;
    clear_ctl();
    m_z = {32'h0, 32'h20};
    peek(S_ZL, "op_prio", 32'h20);

    // MUL / DIV
    load_reg(2, 32'hFFFF_FFFE);
    load_reg(3, 32'h3);
    alu(2, 3, OP_MUL);
    peek(S_ZL, "mul_lo", 32'hFFFF_FFFA);
    peek(S_ZH, "mul_hi", 32'hFFFF_FFFF);
    load_reg(8, 32'h7);
    alu(8, 2, OP_DIV);
    peek(S_ZL, "div_q", 32'hFFFF_FFFD);
    peek(S_ZH, "div_r", 32'h1);
    load_reg(9, 32'h0);
    alu(8, 9, OP_DIV);
    peek(S_ZL, "div0_q", 32'hFFFF_FFFF);
    peek(S_ZH, "div0_r", 32'h7);
    load_reg(10, 32'h8000_0000);
    load_reg(11, 32'hFFFF_FFFF);
    alu(10, 11, OP_DIV);
    peek(S_ZL, "divov_q", 32'h8000_0000);
    peek(S_ZH, "divov_r", 32'h0);

    // Shifts and rotates
    load_reg(1, 32'h8000_0001);
    load_reg(12, 32'h4);
    alu(1, 12, OP_SHR);  peek(S_ZL, "shr",  32'h0800_0000);
    alu(1, 12, OP_SHRA); peek(S_ZL, "shra", 32'hF800_0000);
    alu(1, 12, OP_SHL);  peek(S_ZL, "shl",  32'h0000_0010);
    alu(1, 12, OP_ROR);  peek(S_ZL, "ror",  32'h1800_0000);
    alu(1, 12, OP_ROL);  peek(S_ZL, "rol",  32'h0000_0018);

    // HI/LO via Z, same-register source/destination
    alu(2, 3, OP_MUL);
    xfer(S_ZH, D_HI, "zh_to_hi");
    xfer(S_ZL, D_LO, "zl_to_lo");
    peek(S_HI, "hi", 32'hFFFF_FFFF);
    peek(S_LO, "lo", 32'hFFFF_FFFA);
    xfer(5, 5, "self_xfer");
    peek(5, "self_hold", 32'hFFFF_FFDE);

    // Random traffic against the model
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 4))
        0: load_reg(int'($urandom_range(0, 15)), $urandom);
        1: begin
          op = int'($urandom_range(0, OP_NONE));
          alu(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), op);
          peek(S_ZL, "rnd_zl", m_z[31:0]);
          peek(S_ZH, "rnd_zh", m_z[63:32]);
        end
        2: begin
          in_data = $urandom;
          s = int'($urandom_range(0, S_MAR));
          d = int'($urandom_range(0, D_MDR));
          xfer(s, d, "rnd_xfer");
        end
        3: begin
          xfer(S_ZH, D_HI, "rnd_hi");
          xfer(S_ZL, D_LO, "rnd_lo");
          peek(S_HI, "rnd_hi_rd", m_hi);
        end
        default: mem_read($urandom, 1'b1);
      endcase
    end
    for (int i = 0; i < 16; i++) peek(i, "final_reg", m_r[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
